clk_div_multi: RTL and testbench

//  Parametrised N-channel programmable clock divider and tick generator.

---
 rtl/clk_div_multi_if.sv | 37 +++
 rtl/clk_div_multi.sv | 152 +++++++++++++++
 tb/tb_clk_div_multi.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_multi_if.sv
// ----------------------------------------------------------------------------
// clk_div_multi_if
// Bundles the control inputs and the per-channel outputs of clk_div_multi.
//   ch_en    : per-channel run enable
//   sync_rst : restart all channels at count 0 (phase align)
//   cfg_wr   : one-cycle divisor write strobe
//   cfg_ch   : target channel of cfg_wr
//   cfg_div  : new divisor (values below 2 are clamped to 2)
//   ch_out   : divided square wave per channel
//   ch_tick  : one-cycle strobe on the last cycle of each period
//   ch_pend  : written divisor not yet in effect
// The master drives configuration and reads the outputs; the divider is the
// slave.
// ----------------------------------------------------------------------------
interface clk_div_multi_if #(
  parameter int N_CH  = 4,
  parameter int DIV_W = 20
);
  logic [N_CH-1:0]  ch_en;
  logic             sync_rst;
  logic             cfg_wr;
  logic [3:0]       cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [N_CH-1:0]  ch_out;
  logic [N_CH-1:0]  ch_tick;
  logic [N_CH-1:0]  ch_pend;

  modport master (
    output ch_en, sync_rst, cfg_wr, cfg_ch, cfg_div,
    input  ch_out, ch_tick, ch_pend
  );

  modport slave (
    input  ch_en, sync_rst, cfg_wr, cfg_ch, cfg_div,
    output ch_out, ch_tick, ch_pend
  );
endinterface

// File: rtl/clk_div_multi.sv
// ----------------------------------------------------------------------------
// clk_div_multi
// N-channel runtime-programmable clock divider / tick generator.
// Each channel counts 0..active_div-1 and produces a square wave (low for
// floor(D/2) cycles, high for ceil(D/2) cycles) and a one-cycle tick on the
// last count of the period. New divisors are held in a shadow register and
// only take over at a period boundary, on a sync restart, or while the
// channel is disabled, so the output never glitches mid-period.
// Ports:
//   CLK   : system clock, all logic on posedge
//   RST_N : synchronous active-low reset (count=0, divisors=DEF_DIV)
//   bus   : clk_div_multi_if slave modport (controls and channel outputs)
// ----------------------------------------------------------------------------
module clk_div_multi #(
  parameter int N_CH    = 4,
  parameter int DIV_W   = 20,
  parameter int DEF_DIV = 50000
) (
  input  logic           CLK,
  input  logic           RST_N,
  clk_div_multi_if.slave bus
);

  localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] MIN_DIV   = DIV_W'(2);
  localparam logic [DIV_W-1:0] ONE_V     = DIV_W'(1);
  localparam logic [DIV_W-1:0] ZERO_V    = DIV_W'(0);
  localparam logic [4:0]       N_CH_V    = 5'(N_CH);

  // Divisors of 0 and 1 cannot form a period with both a low and a high phase.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    logic [DIV_W-1:0] res;
    if (d < MIN_DIV) begin
      res = MIN_DIV;
    end else begin
      res = d;
    end
    return res;
  endfunction

  // Per-channel state
  logic [DIV_W-1:0] r_count  [N_CH];
  logic [DIV_W-1:0] r_active [N_CH];
  logic [DIV_W-1:0] r_shadow [N_CH];
  logic [N_CH-1:0]  r_pend;
  logic [N_CH-1:0]  r_out;
  logic [N_CH-1:0]  r_tick;

  // Next-state values
  logic [DIV_W-1:0] w_count_nx  [N_CH];
  logic [DIV_W-1:0] w_active_nx [N_CH];
  logic [DIV_W-1:0] w_shadow_nx [N_CH];
  logic [N_CH-1:0]  w_pend_nx;
  logic [N_CH-1:0]  w_out_nx;
  logic [N_CH-1:0]  w_tick_nx;
  logic [N_CH-1:0]  w_wrap;
  logic [N_CH-1:0]  w_apply;
  logic [N_CH-1:0]  w_hit;
  logic             w_cfg_valid;
  logic [DIV_W-1:0] w_cfg_div_cl;

  // Writes addressed beyond the last channel are dropped.
  assign w_cfg_valid  = bus.cfg_wr && ({1'b0, bus.cfg_ch} < N_CH_V);
  assign w_cfg_div_cl = clamp_div(bus.cfg_div);

  // Per-channel next state: disable > sync restart > wrap > increment.
  always_comb begin
    w_pend_nx = r_pend;
    w_out_nx  = '0;
    w_tick_nx = '0;
    w_wrap    = '0;
    w_apply   = '0;
    w_hit     = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_count_nx[i]  = r_count[i];
      w_active_nx[i] = r_active[i];
      w_shadow_nx[i] = r_shadow[i];

      w_wrap[i] = (r_count[i] == (r_active[i] - ONE_V));
      w_hit[i]  = w_cfg_valid && (bus.cfg_ch == 4'(i));

      if (!bus.ch_en[i]) begin
        w_count_nx[i] = ZERO_V;
        w_apply[i]    = r_pend[i];
      end else if (bus.sync_rst) begin
        w_count_nx[i] = ZERO_V;
        w_apply[i]    = r_pend[i];
      end else if (w_wrap[i]) begin
        w_count_nx[i] = ZERO_V;
        w_apply[i]    = r_pend[i];
      end else begin
        w_count_nx[i] = r_count[i] + ONE_V;
        w_apply[i]    = 1'b0;
      end

      // A pending divisor takes over only where a new period begins.
      if (w_apply[i]) begin
        w_active_nx[i] = r_shadow[i];
        w_pend_nx[i]   = 1'b0;
      end else begin
        w_active_nx[i] = r_active[i];
        w_pend_nx[i]   = r_pend[i];
      end

      // A write on the same edge as a boundary lands in the shadow and waits
      // for the following boundary; the old shadow has already been applied.
      if (w_hit[i]) begin
        w_shadow_nx[i] = w_cfg_div_cl;
        w_pend_nx[i]   = 1'b1;
      end else begin
        w_shadow_nx[i] = r_shadow[i];
      end

      // Outputs are computed from the next count so they line up with it.
      if (bus.ch_en[i]) begin
        w_out_nx[i]  = (w_count_nx[i] >= (w_active_nx[i] >> 1));
        w_tick_nx[i] = (w_count_nx[i] == (w_active_nx[i] - ONE_V));
      end else begin
        w_out_nx[i]  = 1'b0;
        w_tick_nx[i] = 1'b0;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < N_CH; i++) begin
        r_count[i]  <= ZERO_V;
        r_active[i] <= DEF_DIV_V;
        r_shadow[i] <= DEF_DIV_V;
      end
      r_pend <= '0;
      r_out  <= '0;
      r_tick <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        r_count[i]  <= w_count_nx[i];
        r_active[i] <= w_active_nx[i];
        r_shadow[i] <= w_shadow_nx[i];
      end
      r_pend <= w_pend_nx;
      r_out  <= w_out_nx;
      r_tick <= w_tick_nx;
    end
  end

  assign bus.ch_out  = r_out;
  assign bus.ch_tick = r_tick;
  assign bus.ch_pend = r_pend;

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: a cycle model of each channel's period position is
// compared with the DUT every cycle, and directed scenarios pin the model
// with hand-computed values.
module tb_clk_div_multi;
  localparam int N  = 4;
  localparam int W  = 20;
  localparam int DD = 50000;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  bit   chk_on;

  clk_div_multi_if #(.N_CH(N), .DIV_W(W)) bus ();

  clk_div_multi #(.N_CH(N), .DIV_W(W), .DEF_DIV(DD)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model: position within the period per channel ----------
  int m_pos [N];
  int m_per [N];
  int m_nxt [N];
  bit m_pend [N];
  bit m_run [N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        m_pos[i] = 0; m_per[i] = DD; m_nxt[i] = DD; m_pend[i] = 0; m_run[i] = 0;
      end else begin
        bit starts;
        m_run[i] = bus.ch_en[i];
        if (!bus.ch_en[i] || bus.sync_rst || m_pos[i] + 1 == m_per[i]) begin
          m_pos[i] = 0;
          starts = 1;
        end else begin
          m_pos[i] = m_pos[i] + 1;
          starts = 0;
        end
        if (starts && m_pend[i]) begin
          m_per[i] = m_nxt[i];
          m_pend[i] = 0;
        end
        if (bus.cfg_wr && int'(bus.cfg_ch) == i) begin
          m_nxt[i] = (int'(bus.cfg_div) < 2) ? 2 : int'(bus.cfg_div);
          m_pend[i] = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      logic [N-1:0] e_out, e_tick, e_pend;
      for (int i = 0; i < N; i++) begin
        e_out[i]  = m_run[i] && (m_pos[i] >= m_per[i] / 2);
        e_tick[i] = m_run[i] && (m_pos[i] == m_per[i] - 1);
        e_pend[i] = m_pend[i];
      end
      n_chk = n_chk + 3;
      if (bus.ch_out !== e_out) begin
        n_err++;
        if (n_err < 30) $display("FAIL model_out t=%0t got %b exp %b", $time, bus.ch_out, e_out);
      end
      if (bus.ch_tick !== e_tick) begin
        n_err++;
        if (n_err < 30) $display("FAIL model_tick t=%0t got %b exp %b", $time, bus.ch_tick, e_tick);
      end
      if (bus.ch_pend !== e_pend) begin
        n_err++;
        if (n_err < 30) $display("FAIL model_pend t=%0t got %b exp %b", $time, bus.ch_pend, e_pend);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int ch, input int dv);
    bus.cfg_wr  = 1'b1;
    bus.cfg_ch  = 4'(ch);
    bus.cfg_div = W'(dv);
    @(negedge clk);
    bus.cfg_wr  = 1'b0;
  endtask

  task automatic pulse_sync();
    bus.sync_rst = 1'b1;
    @(negedge clk);
    bus.sync_rst = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int pat_out [5];
    int coin;
    int first_coin;
    n_chk = 0; n_err = 0; chk_on = 0;
    pat_out = '{0, 0, 1, 1, 1};
    rst_n = 1'b0;
    bus.ch_en = 4'hF; bus.sync_rst = 1'b0; bus.cfg_wr = 1'b0;
    bus.cfg_ch = 4'd0; bus.cfg_div = '0;
    step(1);
    chk_on = 1;
    step(2);
    chk("rst_out",  32'(bus.ch_out),  32'h0);
    chk("rst_tick", 32'(bus.ch_tick), 32'h0);
    chk("rst_pend", 32'(bus.ch_pend), 32'h0);
    rst_n = 1'b1;

    // T1: default divisor 50000
    step(24999);
    chk("t1_out_lo_24999", 32'(bus.ch_out), 32'h0);
    step(1);
    chk("t1_out_hi_25000", 32'(bus.ch_out), 32'hF);
    step(24998);
    chk("t1_no_tick_49998", 32'(bus.ch_tick), 32'h0);
    step(1);
    chk("t1_tick_49999", 32'(bus.ch_tick), 32'hF);
    step(1);
    chk("t1_wrap_tick", 32'(bus.ch_tick), 32'h0);
    chk("t1_wrap_out",  32'(bus.ch_out),  32'h0);

    // bring all channels to divisor 8 in phase
    wr(0, 8); wr(1, 8); wr(2, 8); wr(3, 8);
    pulse_sync();
    chk("setup_pend", 32'(bus.ch_pend), 32'h0);

    // T2: ch1 div 5 written mid-period
    step(2);
    wr(1, 5);
    chk("t2_pend_set", 32'(bus.ch_pend), 32'h2);
    step(4);
    chk("t2_old_tick", 32'(bus.ch_tick), 32'hF);
    chk("t2_pend_hold", 32'(bus.ch_pend), 32'h2);
    step(1);
    chk("t2_pend_clr", 32'(bus.ch_pend), 32'h0);
    for (int k = 0; k < 10; k++) begin
      chk("t2_out1",  32'(bus.ch_out[1]),  32'(pat_out[k % 5]));
      chk("t2_tick1", 32'(bus.ch_tick[1]), 32'((k % 5) == 4));
      step(1);
    end

    // T3: divisors 0 and 1 clamp to 2
    wr(2, 0); wr(2, 1);
    pulse_sync();
    for (int k = 0; k < 4; k++) begin
      chk("t3_out2",  32'(bus.ch_out[2]),  32'(k % 2));
      chk("t3_tick2", 32'(bus.ch_tick[2]), 32'(k % 2));
      step(1);
    end

    // T4: last write wins (9, never 7)
    wr(0, 7); wr(0, 9);
    pulse_sync();
    step(6);
    chk("t4_no_tick_at_6", 32'(bus.ch_tick[0]), 32'h0);
    step(2);
    chk("t4_tick_at_8", 32'(bus.ch_tick[0]), 32'h1);

    // T5: div 4 and 6 phase-aligned, ticks coincide every 12 cycles
    wr(0, 4); wr(3, 6);
    pulse_sync();
    coin = 0; first_coin = -1;
    for (int k = 0; k < 24; k++) begin
      if (bus.ch_tick[0] && bus.ch_tick[3]) begin
        if (first_coin < 0) first_coin = k;
        coin++;
      end
      step(1);
    end
    chk("t5_coincidences", 32'(coin), 32'd2);
    chk("t5_first_coin",   32'(first_coin), 32'd11);

    // write on the wrap edge waits for the following boundary
    step(3);
    chk("wrapwr_tick_before", 32'(bus.ch_tick[0]), 32'h1);
    wr(0, 6);
    chk("wrapwr_pend", 32'(bus.ch_pend[0]), 32'h1);
    step(3);
    chk("wrapwr_old_period", 32'(bus.ch_tick[0]), 32'h1);
    step(1);
    chk("wrapwr_applied", 32'(bus.ch_pend[0]), 32'h0);

    // T6: disable with pending div 3, re-enable
    pulse_sync();
    step(1);
    wr(1, 3);
    chk("t6_pend", 32'(bus.ch_pend[1]), 32'h1);
    bus.ch_en = 4'b1101;
    step(1);
    chk("t6_off_out",  32'(bus.ch_out[1]),  32'h0);
    chk("t6_off_pend", 32'(bus.ch_pend[1]), 32'h0);
    step(2);
    chk("t6_off_out2", 32'(bus.ch_out[1]),  32'h0);
    chk("t6_off_tick", 32'(bus.ch_tick[1]), 32'h0);
    bus.ch_en = 4'hF;
    step(1);
    chk("t6_on1_out",  32'(bus.ch_out[1]),  32'h1);
    chk("t6_on1_tick", 32'(bus.ch_tick[1]), 32'h0);
    step(1);
    chk("t6_on2_tick", 32'(bus.ch_tick[1]), 32'h1);
    step(1);
    chk("t6_on3_out",  32'(bus.ch_out[1]),  32'h0);
    wr(9, 2);
    chk("t6_bad_ch_pend", 32'(bus.ch_pend), 32'h0);
    step(5);

    // reset mid-period
    rst_n = 1'b0;
    step(1);
    chk("rst2_out",  32'(bus.ch_out),  32'h0);
    chk("rst2_pend", 32'(bus.ch_pend), 32'h0);
    rst_n = 1'b1;
    step(10);

    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
